// File: rtl/traffic_light_monitor.sv
// Passive safety/sequencing checker for the traffic controller's light and pedestrian bus.
// Optional TLM_ERR_COUNT_EN adds err_count, a saturating count of cycles with a violation.
module traffic_light_monitor #(
   parameter int MIN_YELLOW = 3,
   parameter int MAX_STUCK  = 64
) (
   input  logic       clk,
   input  logic       rst_a,
   input  logic [2:0] main_north_lights,
   input  logic [2:0] main_south_lights,
   input  logic [2:0] local_east_lights,
   input  logic [2:0] local_west_lights,
   input  logic [3:0] ped_walk,
   input  logic       enable_l,
   input  logic       clr_err,
   output logic       err_conflict,
   output logic       err_encoding,
   output logic       err_transition,
   output logic       err_yellow_short,
   output logic       err_ped,
   output logic       err_stuck,
   output logic       fault,
   output logic [2:0] first_err_code,
   output logic [1:0] first_err_dir
`ifdef TLM_ERR_COUNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam int SW = $clog2(MAX_STUCK + 1);
   localparam int YW = $clog2(MIN_YELLOW + 1);
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;

   logic [3:0][2:0]    cur;
   logic [3:0][2:0]    prev_q;
   logic [3:0][YW-1:0] ycnt_q, ycnt_nxt;
   logic [SW-1:0]      stuck_q, stuck_nxt;

   logic       changed;
   logic       conflict_v, stuck_v, any_v;
   logic [3:0] enc_v, trans_v, ys_v, ped_v;
   logic [2:0] code_sel;
   logic [1:0] dir_sel;

   function automatic logic is_legal(input logic [2:0] v);
      return (v == RED) || (v == YEL) || (v == GRN);
   endfunction

   function automatic logic [1:0] low_idx(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (m[i]) r = 2'(i);
      end
      return r;
   endfunction

   assign cur = {local_west_lights, local_east_lights, main_south_lights, main_north_lights};

   always_comb begin
      changed    = (cur != prev_q);
      conflict_v = 1'b0;
      stuck_v    = 1'b0;
      enc_v      = '0;
      trans_v    = '0;
      ys_v       = '0;
      ped_v      = '0;
      stuck_nxt  = '0;
      ycnt_nxt   = '0;
      if (enable_l) begin
         if (changed)
            stuck_nxt = '0;
         else if (stuck_q == SW'(MAX_STUCK))
            stuck_nxt = stuck_q;
         else
            stuck_nxt = stuck_q + 1'b1;
         stuck_v    = (stuck_nxt == SW'(MAX_STUCK));
         conflict_v = ((cur[0] != RED) || (cur[1] != RED)) &&
                      ((cur[2] != RED) || (cur[3] != RED));
         for (int d = 0; d < 4; d++) begin
            if (cur[d] == YEL)
               ycnt_nxt[d] = (ycnt_q[d] == YW'(MIN_YELLOW)) ? ycnt_q[d] : ycnt_q[d] + 1'b1;
            // Steps touching an illegal code are reported as encoding only.
            enc_v[d]   = !is_legal(cur[d]) || !is_legal(prev_q[d]);
            trans_v[d] = !enc_v[d] &&
                         (((prev_q[d] == GRN) && (cur[d] == RED)) ||
                          ((prev_q[d] == YEL) && (cur[d] == GRN)) ||
                          ((prev_q[d] == RED) && (cur[d] == YEL)));
            ys_v[d]    = (prev_q[d] == YEL) && (cur[d] == RED) &&
                         (ycnt_q[d] < YW'(MIN_YELLOW));
            ped_v[d]   = ped_walk[d] && (cur[d] != RED);
         end
      end
   end

   always_comb begin
      code_sel = 3'd0;
      dir_sel  = 2'd0;
      if (conflict_v) begin
         code_sel = 3'd1;
      end else if (|enc_v) begin
         code_sel = 3'd2;
         dir_sel  = low_idx(enc_v);
      end else if (|trans_v) begin
         code_sel = 3'd3;
         dir_sel  = low_idx(trans_v);
      end else if (|ys_v) begin
         code_sel = 3'd4;
         dir_sel  = low_idx(ys_v);
      end else if (|ped_v) begin
         code_sel = 3'd5;
         dir_sel  = low_idx(ped_v);
      end else if (stuck_v) begin
         code_sel = 3'd6;
      end
   end

   assign any_v = (code_sel != 3'd0);

   always_ff @(posedge clk) begin
      if (rst_a) begin
         prev_q           <= {4{RED}};
         ycnt_q           <= '0;
         stuck_q          <= '0;
         err_conflict     <= 1'b0;
         err_encoding     <= 1'b0;
         err_transition   <= 1'b0;
         err_yellow_short <= 1'b0;
         err_ped          <= 1'b0;
         err_stuck        <= 1'b0;
         first_err_code   <= 3'd0;
         first_err_dir    <= 2'd0;
      end else begin
         prev_q           <= cur;
         ycnt_q           <= ycnt_nxt;
         stuck_q          <= stuck_nxt;
         // A violation in the clearing cycle survives the clear.
         err_conflict     <= (err_conflict     & ~clr_err) | conflict_v;
         err_encoding     <= (err_encoding     & ~clr_err) | (|enc_v);
         err_transition   <= (err_transition   & ~clr_err) | (|trans_v);
         err_yellow_short <= (err_yellow_short & ~clr_err) | (|ys_v);
         err_ped          <= (err_ped          & ~clr_err) | (|ped_v);
         err_stuck        <= (err_stuck        & ~clr_err) | stuck_v;
         if (clr_err || (first_err_code == 3'd0)) begin
            first_err_code <= code_sel;
            first_err_dir  <= dir_sel;
         end
      end
   end

   assign fault = err_conflict | err_encoding | err_transition |
                  err_yellow_short | err_ped | err_stuck;

`ifdef TLM_ERR_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst_a) begin
         err_count <= 8'd0;
      end else if (any_v) begin
         if (clr_err)
            err_count <= 8'd1;
         else if (err_count != 8'hff)
            err_count <= err_count + 8'd1;
      end else if (clr_err) begin
         err_count <= 8'd0;
      end
   end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed scenarios then randomized light walks,
// checked every cycle against a rule-level reference model.
module tb_traffic_light_monitor;

   localparam int MIN_YELLOW = 3;
   localparam int MAX_STUCK  = 64;
   localparam int W = 20;
   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   logic       clk = 1'b0;
   logic       rst_a = 1'b1;
   logic [2:0] lt [4];
   logic [3:0] ped_walk = 4'd0;
   logic       enable_l = 1'b0;
   logic       clr_err = 1'b0;
   logic       err_conflict, err_encoding, err_transition, err_yellow_short, err_ped, err_stuck;
   logic       fault;
   logic [2:0] first_err_code;
   logic [1:0] first_err_dir;
   logic [7:0] dut_cnt;

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // reference model state
   logic [2:0] mprev [4];
   int         yrun [4];
   int         srun;
   logic [5:0] mflags;
   logic [2:0] mcode;
   logic [1:0] mdir;
   int         mcnt;

   always #5 clk = ~clk;

   traffic_light_monitor #(.MIN_YELLOW(MIN_YELLOW), .MAX_STUCK(MAX_STUCK)) dut (
      .clk(clk),
      .rst_a(rst_a),
      .main_north_lights(lt[0]),
      .main_south_lights(lt[1]),
      .local_east_lights(lt[2]),
      .local_west_lights(lt[3]),
      .ped_walk(ped_walk),
      .enable_l(enable_l),
      .clr_err(clr_err),
      .err_conflict(err_conflict),
      .err_encoding(err_encoding),
      .err_transition(err_transition),
      .err_yellow_short(err_yellow_short),
      .err_ped(err_ped),
      .err_stuck(err_stuck),
      .fault(fault),
      .first_err_code(first_err_code),
      .first_err_dir(first_err_dir)
`ifdef TLM_ERR_COUNT_EN
      ,
      .err_count(dut_cnt)
`endif
   );

`ifndef TLM_ERR_COUNT_EN
   assign dut_cnt = 8'd0;
`endif

   function automatic logic is_legal(input logic [2:0] v);
      return (v == R) || (v == Y) || (v == G);
   endfunction

   function automatic logic [2:0] succ(input logic [2:0] v);
      return (v == R) ? G : (v == G) ? Y : R;
   endfunction

   function automatic logic [W-1:0] pack_exp();
      logic [7:0] c;
`ifdef TLM_ERR_COUNT_EN
      c = 8'(mcnt);
`else
      c = 8'd0;
`endif
      return {mflags[0], mflags[1], mflags[2], mflags[3], mflags[4], mflags[5],
              |mflags, mcode, mdir, c};
   endfunction

   task automatic model_step();
      logic [5:0] v;
      logic [1:0] vd [6];
      logic       changed;
      if (rst_a) begin
         for (int d = 0; d < 4; d++) begin
            mprev[d] = R;
            yrun[d]  = 0;
         end
         srun = 0; mflags = '0; mcode = 3'd0; mdir = 2'd0; mcnt = 0;
         return;
      end
      changed = 1'b0;
      v = '0;
      for (int i = 0; i < 6; i++) vd[i] = 2'd0;
      for (int d = 0; d < 4; d++) if (lt[d] != mprev[d]) changed = 1'b1;
      if (enable_l) begin
         srun = changed ? 0 : srun + 1;
         if (((lt[0] != R) || (lt[1] != R)) && ((lt[2] != R) || (lt[3] != R))) v[0] = 1'b1;
         for (int d = 3; d >= 0; d--) begin
            if (!is_legal(lt[d]) || !is_legal(mprev[d])) begin
               v[1] = 1'b1; vd[1] = 2'(d);
            end else if (lt[d] != mprev[d] && lt[d] != succ(mprev[d])) begin
               v[2] = 1'b1; vd[2] = 2'(d);
            end
            if (mprev[d] == Y && lt[d] == R && yrun[d] < MIN_YELLOW) begin
               v[3] = 1'b1; vd[3] = 2'(d);
            end
            if (ped_walk[d] && lt[d] != R) begin
               v[4] = 1'b1; vd[4] = 2'(d);
            end
         end
         if (srun >= MAX_STUCK) v[5] = 1'b1;
         for (int d = 0; d < 4; d++) yrun[d] = (lt[d] == Y) ? yrun[d] + 1 : 0;
      end else begin
         srun = 0;
         for (int d = 0; d < 4; d++) yrun[d] = 0;
      end
      mflags = clr_err ? v : (mflags | v);
      if (clr_err || mcode == 3'd0) begin
         mcode = 3'd0; mdir = 2'd0;
         for (int i = 5; i >= 0; i--) begin
            if (v[i]) begin
               mcode = 3'(i + 1); mdir = vd[i];
            end
         end
      end
      if (v != '0) mcnt = clr_err ? 1 : ((mcnt < 255) ? mcnt + 1 : 255);
      else if (clr_err) mcnt = 0;
      for (int d = 0; d < 4; d++) mprev[d] = lt[d];
   endtask

   task automatic apply(input logic [2:0] n, s, e, w, input logic [3:0] walk,
                        input logic en, input logic clr, input logic rst);
      @(negedge clk);
      lt[0] = n; lt[1] = s; lt[2] = e; lt[3] = w;
      ped_walk = walk; enable_l = en; clr_err = clr; rst_a = rst;
      model_step();
      exp_q.push_back(pack_exp());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply(R, R, R, R, 4'd0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic clear();
      apply(R, R, R, R, 4'd0, 1'b1, 1'b1, 1'b0);
   endtask

   // Monitor: one expected output word per driven cycle.
   always @(posedge clk) begin
      logic [W-1:0] got, exp;
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         got = {err_conflict, err_encoding, err_transition, err_yellow_short, err_ped, err_stuck,
                fault, first_err_code, first_err_dir, dut_cnt};
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL outputs cyc=%0d got flags=%b fault=%b code=%0d dir=%0d cnt=%0d exp flags=%b fault=%b code=%0d dir=%0d cnt=%0d",
                     cyc, got[19:14], got[13], got[12:10], got[9:8], got[7:0],
                     exp[19:14], exp[13], exp[12:10], exp[9:8], exp[7:0]);
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] rl [4];
      logic [2:0] bad;
      int r;
      for (int d = 0; d < 4; d++) lt[d] = R;
      apply(R, R, R, R, 4'd0, 1'b0, 1'b0, 1'b1);
      apply(R, R, R, R, 4'd0, 1'b0, 1'b0, 1'b1);
      idle(10);
      // North full legal cycle, then short yellow
      apply(G, R, R, R, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) apply(Y, R, R, R, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(2);
      apply(G, R, R, R, 4'd0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) apply(Y, R, R, R, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(2);
      clear();
      // Conflict then encoding
      apply(G, R, G, R, 4'd0, 1'b1, 1'b0, 1'b0);
      apply(G, R, G, 3'b011, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(2);
      clear();
      // South G->R
      apply(R, G, R, R, 4'd0, 1'b1, 1'b0, 1'b0);
      apply(R, R, R, R, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(1);
      clear();
      idle(1);
      // Pedestrian with East green, enabled then disabled
      apply(R, R, G, R, 4'b0100, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) apply(R, R, Y, R, 4'd0, 1'b1, 1'b0, 1'b0);
      idle(1);
      clear();
      apply(R, R, G, R, 4'b0100, 1'b0, 1'b0, 1'b0);
      apply(R, R, Y, R, 4'b0100, 1'b0, 1'b0, 1'b0);
      apply(R, R, R, R, 4'd0, 1'b0, 1'b0, 1'b0);
      // Frozen red, beyond the stuck limit
      clear();
      idle(MAX_STUCK + 6);
      clear();
      // Randomized walks
      for (int d = 0; d < 4; d++) rl[d] = R;
      for (int k = 0; k < 3000; k++) begin
         for (int d = 0; d < 4; d++) begin
            r = $urandom_range(0, 63);
            if (r == 0) begin
               rl[d] = 3'($urandom_range(0, 7));
            end else if (r < 3) begin
               bad = (rl[d] == G) ? R : (rl[d] == Y) ? G : Y;
               rl[d] = bad;
            end else if (r < 16) begin
               rl[d] = succ(rl[d]);
            end
         end
         apply(rl[0], rl[1], rl[2], rl[3],
               ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
               ($urandom_range(0, 31) != 0),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 499) == 0));
      end
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive checker on the receiving end of the traffic controller's light/pedestrian output bus.
- Samples the four 3-bit light vectors and four pedestrian walk signals every clock.
- Flags safety and sequencing violations with sticky error flags, a summary fault and first-error capture.
- Instantiated beside Top in simulation and on hardware for fault reporting; drives nothing back into the controller.

Parameters:
- MIN_YELLOW, 3: minimum consecutive yellow samples required before red.
- MAX_STUCK, 64: cycles with no light change before the stuck error; width of the stuck counter is $clog2(MAX_STUCK+1).

Ports:
- clk  input  1  system clock, rising edge
- rst_a  input  1  synchronous, active-high reset
- main_north_lights  input  3  light encoding: 3'b100 red, 3'b010 yellow, 3'b001 green
- main_south_lights  input  3  same encoding
- local_east_lights  input  3  same encoding
- local_west_lights  input  3  same encoding
- ped_walk  input  4  walk per direction: [0]N [1]S [2]E [3]W
- enable_l  input  1  checking enable; low pauses all checks
- clr_err  input  1  synchronous clear of sticky flags and first-error capture
- err_conflict  output  1  sticky: a main light and a local light both non-red
- err_encoding  output  1  sticky: a light vector is not one of the three legal codes
- err_transition  output  1  sticky: illegal step G->R, Y->G or R->Y
- err_yellow_short  output  1  sticky: Y->R after fewer than MIN_YELLOW yellow samples
- err_ped  output  1  sticky: walk asserted while own-direction light is non-red
- err_stuck  output  1  sticky: no light vector changed for MAX_STUCK cycles
- fault  output  1  OR of all six sticky flags
- first_err_code  output  3  0 none, 1 conflict, 2 encoding, 3 transition, 4 yellow_short, 5 ped, 6 stuck
- first_err_dir  output  2  direction of the first error (0 N, 1 S, 2 E, 3 W)

Behaviour:
- Reset (rst_a high at edge): all flags 0, fault 0, first_err_code 0, first_err_dir 0, prev light registers 3'b100, yellow counters 0, stuck counter 0.
- Latency: a violation present on the inputs at edge k sets its flag at edge k, so the flag is visible from cycle k+1.
- Per-direction prev register always updates with the sampled vector, including when enable_l is low.
- Transition check compares prev against current. Legal steps: R->G, G->Y, Y->R, and any hold. Any step into or out of an illegal code counts as an encoding error only, not a transition error.
- Yellow counter, per direction:
  - Increments, saturating at MIN_YELLOW, while the current sample is yellow.
  - Cleared when the current sample is not yellow.
  - On Y->R, an error is raised if the counter is below MIN_YELLOW.
- Stuck counter:
  - Clears whenever any of the four vectors differs from prev; otherwise increments, saturating at MAX_STUCK.
  - err_stuck sets when the counter reaches MAX_STUCK.
- enable_l low: no flag may set, yellow and stuck counters clear, and existing flags hold.
- clr_err high: flags and first-error capture clear. A violation detected in the same cycle wins; its flag is set and it is captured as the new first error.
- First-error capture:
  - Loads only while first_err_code is 0.
  - Simultaneous errors use priority by code (1 highest).
  - Direction is the lowest-index offending direction. Conflict and stuck report dir 0.
- fault is combinational OR of the registered flags.

Optional Feature:
- Macro TLM_ERR_COUNT_EN.
- Defined: adds output err_count[7:0], incremented by 1 on every cycle in which at least one new violation is detected (flag set or already set), saturating at 255. It is cleared by rst_a and clr_err; in a same-cycle violation it loads 1.
- Undefined: the port and logic are absent.

Test Plan:
- Reset, then all lights 3'b100 and enable_l=1 held 10 cycles -> all flags 0, first_err_code 0.
- N: R->G->Y(3 cycles)->R, other directions red -> no flags. Repeat with Y held 2 cycles -> err_yellow_short=1 one cycle after the red sample, first_err_code 4, first_err_dir 0.
- N green and E set to 3'b001 in the same cycle -> err_conflict=1 next cycle, code 1, dir 0. Then W=3'b011 -> err_encoding=1, and the code stays 1.
- S steps G->R directly -> err_transition=1, code 3, dir 1. Then pulse clr_err with no violation -> all flags 0, code 0.
- ped_walk=4'b0100 while E is green -> err_ped=1, code 5, dir 2. The same stimulus with enable_l=0 -> no flag.
- All lights frozen at red for 64 cycles -> err_stuck=1 after the 64th cycle, code 6. With TLM_ERR_COUNT_EN defined, err_count increments every following cycle.
